// File: rtl/ldtu_lane_serializer.sv
// rtl/ldtu_lane_serializer.sv - per-lane MSB-first word serializer with idle/sync insertion
module ldtu_lane_serializer #(
    parameter int                  Nbits_32  = 32,
    parameter logic [Nbits_32-1:0] IDLE_WORD = 32'hEAAAAAAA,
    parameter int                  N_SYNC    = 4,
    parameter int                  CntBits   = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [Nbits_32-1:0] DATA32,
    input  logic                word_valid,
    input  logic                align,
    input  logic                cnt_clr,
    output logic                ready,
    output logic                SER_OUT,
    output logic                frame_start,
    output logic                in_sync,
    output logic [CntBits-1:0]  data_cnt,
    output logic [CntBits-1:0]  idle_cnt
);

    localparam int BW = $clog2(Nbits_32);
    localparam int SW = $clog2(N_SYNC + 1);
    localparam logic [BW-1:0]      LAST_BIT = BW'(Nbits_32 - 1);
    localparam logic [SW-1:0]      LAST_SYNC = SW'(N_SYNC - 1);
    localparam logic [CntBits-1:0] CNT_MAX = '1;

    typedef enum logic {ST_SYNC, ST_RUN} state_t;

    state_t              r_state, w_state_nxt;
    logic [Nbits_32-1:0] r_sh;
    logic [BW-1:0]       r_bcnt;
    logic [SW-1:0]       r_sync_cnt, w_sync_nxt, w_idx;
    logic                r_align_pend, w_align_pend_nxt;
    logic                r_frame;
    logic [CntBits-1:0]  r_data_cnt, r_idle_cnt;
    logic                w_boundary, w_align_any, w_take;

    assign w_boundary  = (r_bcnt == LAST_BIT);
    assign w_align_any = align | r_align_pend;
    assign ready       = w_boundary & (r_state == ST_RUN) & ~w_align_any;
    assign w_take      = ready & word_valid;

    assign SER_OUT     = r_sh[Nbits_32-1];
    assign frame_start = r_frame;
    assign in_sync     = (r_state == ST_SYNC);
    assign data_cnt    = r_data_cnt;
    assign idle_cnt    = r_idle_cnt;

    // An align at a boundary counts the idle word loaded there as sync word 1,
    // so a fresh or restarted SYNC run starts from index 0 here.
    always_comb begin
        w_state_nxt      = r_state;
        w_sync_nxt       = r_sync_cnt;
        w_align_pend_nxt = r_align_pend;
        w_idx            = r_sync_cnt;
        if (w_boundary) begin
            w_align_pend_nxt = 1'b0;
            if ((r_state == ST_SYNC) || w_align_any) begin
                w_idx = w_align_any ? '0 : r_sync_cnt;
                if (w_idx == LAST_SYNC) begin
                    w_state_nxt = ST_RUN;
                    w_sync_nxt  = '0;
                end else begin
                    w_state_nxt = ST_SYNC;
                    w_sync_nxt  = w_idx + 1'b1;
                end
            end
        end else if (align) begin
            w_align_pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= ST_SYNC;
            r_sync_cnt   <= '0;
            r_align_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sync_cnt   <= w_sync_nxt;
            r_align_pend <= w_align_pend_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sh    <= IDLE_WORD;
            r_bcnt  <= LAST_BIT;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_boundary;
            if (w_boundary) begin
                r_sh   <= w_take ? DATA32 : IDLE_WORD;
                r_bcnt <= '0;
            end else begin
                r_sh   <= {r_sh[Nbits_32-2:0], 1'b0};
                r_bcnt <= r_bcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_data_cnt <= '0;
            r_idle_cnt <= '0;
        end else if (cnt_clr) begin
            r_data_cnt <= '0;
            r_idle_cnt <= '0;
        end else if (w_boundary) begin
            if (w_take && (r_data_cnt != CNT_MAX))
                r_data_cnt <= r_data_cnt + 1'b1;
            if (!w_take && (r_idle_cnt != CNT_MAX))
                r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

endmodule
